// File: rtl/seg7_sched_pkg.sv
// Shared types and the hex-to-segment decoder for the 7-segment display scheduler.
package seg7_sched_pkg;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} sched_state_t;

   // Segment order {a,b,c,d,e,f,g}; b and d use the lowercase shapes.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'b111_1110;
         4'h1: seg = 7'b011_0000;
         4'h2: seg = 7'b110_1101;
         4'h3: seg = 7'b111_1001;
         4'h4: seg = 7'b011_0011;
         4'h5: seg = 7'b101_1011;
         4'h6: seg = 7'b101_1111;
         4'h7: seg = 7'b111_0000;
         4'h8: seg = 7'b111_1111;
         4'h9: seg = 7'b111_1011;
         4'hA: seg = 7'b111_0111;
         4'hB: seg = 7'b001_1111;
         4'hC: seg = 7'b100_1110;
         4'hD: seg = 7'b011_1101;
         4'hE: seg = 7'b100_1111;
         default: seg = 7'b100_0111;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit scan timer: slot counter, digit index and a registered end-of-frame pulse.
module seg7_scan_timer #(
   parameter int w_digit      = 8,
   parameter int digit_cycles = 50000,
   localparam int CW = (digit_cycles > 1) ? $clog2(digit_cycles) : 1,
   localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [CW-1:0] cnt,
   output logic [IW-1:0] idx,
   output logic          frame_end
);

   localparam logic [CW-1:0] CNT_MAX = CW'(digit_cycles - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(w_digit - 1);

   logic [CW-1:0] cnt_nx;
   logic [IW-1:0] idx_nx;

   always_comb begin
      cnt_nx = cnt + 1'b1;
      idx_nx = idx;
      if (cnt == CNT_MAX) begin
         cnt_nx = '0;
         idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // frame_end is decoded from the next count so it leaves a flop, free of glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         idx       <= '0;
         frame_end <= 1'b0;
      end else begin
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         frame_end <= (cnt_nx == CNT_MAX) && (idx_nx == IDX_MAX);
      end
   end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Round-robin, frame-aligned sharing of a multiplexed 7-segment display among requesters,
// with a minimum hold time per owner and a per-frame snapshot of the owner's digits.
module seg7_display_scheduler
   import seg7_sched_pkg::*;
#(
   parameter int w_digit      = 8,
   parameter int n_req        = 4,
   parameter int digit_cycles = 50000,
   parameter int hold_frames  = 250
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [n_req-1:0]           req,
   input  logic [n_req*w_digit*4-1:0] value,
   input  logic [n_req*w_digit-1:0]   dots,
   output logic [n_req-1:0]           grant,
   output logic                       frame_end,
   output logic [7:0]                 abcdefgh,
   output logic [w_digit-1:0]         digit
);

   localparam int OW = (n_req > 1) ? $clog2(n_req) : 1;
   localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
   localparam int CW = (digit_cycles > 1) ? $clog2(digit_cycles) : 1;
   localparam int HW = (hold_frames > 1) ? $clog2(hold_frames) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(hold_frames - 1);

   logic [CW-1:0] scan_cnt;
   logic [IW-1:0] scan_idx;

   seg7_scan_timer #(
      .w_digit      (w_digit),
      .digit_cycles (digit_cycles)
   ) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (scan_cnt),
      .idx       (scan_idx),
      .frame_end (frame_end)
   );

   sched_state_t  state, nxt_state;
   logic [OW-1:0] owner, nxt_owner, rr_ptr;
   logic [HW-1:0] hold_cnt;
   logic [OW:0]   pick;
   logic [n_req-1:0] others;
   logic          owner_changed;

   // Returns {found, index} of the first set bit of r scanning upward from start, wrapping.
   function automatic logic [OW:0] rr_pick(input logic [n_req-1:0] r, input int start);
      logic [OW:0] res;
      int k;
      res = '0;
      for (int i = 0; i < n_req; i++) begin
         k = (start + i) % n_req;
         if (!res[OW] && r[k]) res = {1'b1, OW'(k)};
      end
      return res;
   endfunction

   always_comb begin
      others        = req;
      others[owner] = 1'b0;
      pick          = (state == IDLE) ? rr_pick(req, int'(rr_ptr))
                                      : rr_pick(others, int'(owner) + 1);
      nxt_state     = state;
      nxt_owner     = owner;
      if (state == IDLE) begin
         if (pick[OW]) begin
            nxt_state = OWN;
            nxt_owner = pick[OW-1:0];
         end
      end else if (!req[owner]) begin
         if (pick[OW]) nxt_owner = pick[OW-1:0];
         else          nxt_state = IDLE;
      end else if (hold_cnt >= HOLD_MAX && pick[OW]) begin
         nxt_owner = pick[OW-1:0];
      end
      owner_changed = (nxt_state != state) || (nxt_owner != owner);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         grant    <= '0;
      end else if (frame_end) begin
         state <= nxt_state;
         owner <= nxt_owner;
         grant <= (nxt_state == OWN) ? (n_req'(1) << nxt_owner) : '0;
         if (owner_changed) begin
            hold_cnt <= '0;
            if (nxt_state == OWN) rr_ptr <= OW'((int'(nxt_owner) + 1) % n_req);
         end else if (state == OWN && hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Frame buffer stage: the incoming owner's digits are frozen for the whole frame.
   logic [w_digit*4-1:0] frame_val_p0;
   logic [w_digit-1:0]   frame_dot_p0;

   always_ff @(posedge clk) begin
      if (frame_end) begin
         frame_val_p0 <= value[int'(nxt_owner)*w_digit*4 +: w_digit*4];
         frame_dot_p0 <= dots[int'(nxt_owner)*w_digit +: w_digit];
      end
   end

   // Output stage: pins only move on the first cycle of each slot, one cycle after idx changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit    <= '0;
         abcdefgh <= '0;
      end else if (scan_cnt == '0) begin
         if (state == OWN) begin
            digit    <= w_digit'(1) << scan_idx;
            abcdefgh <= {hex_to_seg(frame_val_p0[int'(scan_idx)*4 +: 4]), frame_dot_p0[scan_idx]};
         end else begin
            digit    <= '0;
            abcdefgh <= '0;
         end
      end
   end

endmodule
